// File: rtl/mux_8to1_pkg.sv
// mux_8to1_pkg
//   Shared constants for the 8-to-1 data selector.
//   MUX8_SEL_W         : width of the binary select
//   MUX8_NUM_IN        : number of data inputs
//   MUX8_DEFAULT_WIDTH : default data width of every input and the output
package mux_8to1_pkg;

    localparam int MUX8_SEL_W         = 3;
    localparam int MUX8_NUM_IN        = 8;
    localparam int MUX8_DEFAULT_WIDTH = 8;

endpackage : mux_8to1_pkg

// File: rtl/mux_8to1_out_reg.sv
// out_reg
//   WIDTH-bit output register with synchronous, active-high reset.
//   Ports:
//     Clk   : clock, rising edge
//     Reset : synchronous reset, active high, clears the register to zero
//     d_i   : data captured on each rising edge when not in reset
//     q_o   : registered data
module out_reg
    import mux_8to1_pkg::*;
#(
    parameter int WIDTH = MUX8_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Reset wins over the data path.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q <= '0;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : out_reg

// File: rtl/mux_8to1.sv
// mux_8to1
//   8-to-1 data selector with an optional output register.
//   Parameters:
//     WIDTH      : data width of In1..In8 and DataOut
//     REGISTERED : 0 = combinational output, 1 = output registered on Clk
//   Ports:
//     Clk     : clock, only used when REGISTERED=1
//     Reset   : synchronous active-high reset, only used when REGISTERED=1
//     In1-In8 : data inputs, selected by Sel = 0..7
//     Sel     : binary select
//     DataOut : selected data (same cycle or one cycle later)
module mux_8to1
    import mux_8to1_pkg::*;
#(
    parameter int WIDTH      = MUX8_DEFAULT_WIDTH,
    parameter bit REGISTERED = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [WIDTH-1:0]      In1,
    input  logic [WIDTH-1:0]      In2,
    input  logic [WIDTH-1:0]      In3,
    input  logic [WIDTH-1:0]      In4,
    input  logic [WIDTH-1:0]      In5,
    input  logic [WIDTH-1:0]      In6,
    input  logic [WIDTH-1:0]      In7,
    input  logic [WIDTH-1:0]      In8,
    input  logic [MUX8_SEL_W-1:0] Sel,
    output logic [WIDTH-1:0]      DataOut
);

    logic [WIDTH-1:0] sel_d;

    // All eight codes are legal; the default arm is only reachable when Sel
    // carries X/Z in simulation, where it propagates X to the output.
    always_comb begin
        case (Sel)
            3'd0:    sel_d = In1;
            3'd1:    sel_d = In2;
            3'd2:    sel_d = In3;
            3'd3:    sel_d = In4;
            3'd4:    sel_d = In5;
            3'd5:    sel_d = In6;
            3'd6:    sel_d = In7;
            3'd7:    sel_d = In8;
            default: sel_d = 'x;
        endcase
    end

    if (REGISTERED) begin : g_reg
        out_reg #(
            .WIDTH (WIDTH)
        ) u_out_reg (
            .Clk   (Clk),
            .Reset (Reset),
            .d_i   (sel_d),
            .q_o   (DataOut)
        );
    end else begin : g_comb
        assign DataOut = sel_d;

        // Clock and reset are intentionally unused in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = Clk ^ Reset;
    end

endmodule : mux_8to1

// File: tb/tb_mux_8to1.sv
module tb_mux_8to1;

    logic        clk;
    logic        rst;
    logic [2:0]  sel;
    logic [7:0]  in8  [8];
    logic [15:0] in16 [8];
    logic [7:0]  out_comb;
    logic [7:0]  out_reg8;
    logic [15:0] out_w16;

    int n_tests = 0;
    int n_fail  = 0;

    mux_8to1 #(.WIDTH(8), .REGISTERED(1'b0)) dut_comb (
        .Clk(clk), .Reset(rst),
        .In1(in8[0]), .In2(in8[1]), .In3(in8[2]), .In4(in8[3]),
        .In5(in8[4]), .In6(in8[5]), .In7(in8[6]), .In8(in8[7]),
        .Sel(sel), .DataOut(out_comb)
    );

    mux_8to1 #(.WIDTH(8), .REGISTERED(1'b1)) dut_reg (
        .Clk(clk), .Reset(rst),
        .In1(in8[0]), .In2(in8[1]), .In3(in8[2]), .In4(in8[3]),
        .In5(in8[4]), .In6(in8[5]), .In7(in8[6]), .In8(in8[7]),
        .Sel(sel), .DataOut(out_reg8)
    );

    mux_8to1 #(.WIDTH(16), .REGISTERED(1'b0)) dut_w16 (
        .Clk(clk), .Reset(rst),
        .In1(in16[0]), .In2(in16[1]), .In3(in16[2]), .In4(in16[3]),
        .In5(in16[4]), .In6(in16[5]), .In7(in16[6]), .In8(in16[7]),
        .Sel(sel), .DataOut(out_w16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pattern FF,EE,...,88: input k carries 8'hFF - k*8'h11.
    function automatic logic [7:0] pattern(input int k);
        return 8'(255 - 17 * k);
    endfunction

    task automatic load_pattern();
        for (int k = 0; k < 8; k++) in8[k] = pattern(k);
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1;
        sel = 3'd0;
        load_pattern();
        @(posedge clk); #1;
        n_tests++;
        if (out_reg8 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_clear: got %h want 00", out_reg8);
        end
        n_tests++;
        if (out_comb !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_no_effect_comb: got %h want ff", out_comb);
        end
        @(negedge clk);
        rst = 1'b0;
        exp = in8[0];
        @(posedge clk); #1;
        n_tests++;
        if (out_reg8 !== exp) begin
            n_fail++;
            $display("FAIL reset_release_load: got %h want %h", out_reg8, exp);
        end
    endtask

    task automatic test_comb_vector();
        load_pattern();
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #20;
            n_tests++;
            if (out_comb !== pattern(s)) begin
                n_fail++;
                $display("FAIL comb_vector sel=%0d: got %h want %h", s, out_comb, pattern(s));
            end
        end
    endtask

    task automatic test_isolation();
        load_pattern();
        sel = 3'd3;
        #1;
        for (int r = 0; r < 6; r++) begin
            in8[0] = 8'($urandom);
            in8[1] = 8'($urandom);
            in8[4] = 8'($urandom);
            in8[7] = 8'($urandom);
            #1;
            n_tests++;
            if (out_comb !== 8'hCC) begin
                n_fail++;
                $display("FAIL isolation round %0d: got %h want cc", r, out_comb);
            end
        end
        in8[3] = 8'h5A;
        #1;
        n_tests++;
        if (out_comb !== 8'h5A) begin
            n_fail++;
            $display("FAIL isolation_selected_change: got %h want 5a", out_comb);
        end
    endtask

    task automatic test_registered_latency();
        @(negedge clk);
        rst = 1'b0;
        load_pattern();
        sel = 3'd0;
        @(posedge clk); #1;
        n_tests++;
        if (out_reg8 !== 8'hFF) begin
            n_fail++;
            $display("FAIL reg_latency_pre: got %h want ff", out_reg8);
        end
        @(negedge clk);
        sel = 3'd7;
        #1;
        n_tests++;
        if (out_reg8 !== 8'hFF) begin
            n_fail++;
            $display("FAIL reg_latency_hold: got %h want ff", out_reg8);
        end
        n_tests++;
        if (out_comb !== 8'h88) begin
            n_fail++;
            $display("FAIL comb_zero_latency: got %h want 88", out_comb);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_reg8 !== 8'h88) begin
            n_fail++;
            $display("FAIL reg_latency_update: got %h want 88", out_reg8);
        end
    endtask

    task automatic test_reset_between_edges();
        logic [7:0] held;
        logic [7:0] exp;
        held = out_reg8;
        @(negedge clk);
        rst = 1'b1;
        #2;
        n_tests++;
        if (out_reg8 !== held) begin
            n_fail++;
            $display("FAIL reset_mid_cycle_hold: got %h want %h", out_reg8, held);
        end
        rst = 1'b0;
        sel = 3'd2;
        in8[2] = 8'h3C;
        exp = 8'h3C;
        @(posedge clk); #1;
        n_tests++;
        if (out_reg8 !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_cycle_ignored: got %h want %h", out_reg8, exp);
        end
    endtask

    task automatic test_width16();
        for (int k = 0; k < 8; k++) in16[k] = 16'hFFFF;
        in16[5] = 16'hA5A5;
        sel = 3'd5;
        #1;
        n_tests++;
        if (out_w16 !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL width16_select: got %h want a5a5", out_w16);
        end
        for (int r = 0; r < 10; r++) begin
            int s;
            s = int'($urandom_range(7, 0));
            for (int k = 0; k < 8; k++) in16[k] = 16'($urandom);
            sel = 3'(s);
            #1;
            n_tests++;
            if (out_w16 !== in16[s]) begin
                n_fail++;
                $display("FAIL width16_random sel=%0d: got %h want %h", s, out_w16, in16[s]);
            end
        end
    endtask

    task automatic test_random_comb();
        for (int r = 0; r < 40; r++) begin
            int s;
            s = int'($urandom_range(7, 0));
            for (int k = 0; k < 8; k++) in8[k] = 8'($urandom);
            sel = 3'(s);
            rst = 1'($urandom);
            #3;
            n_tests++;
            if (out_comb !== in8[s]) begin
                n_fail++;
                $display("FAIL comb_random sel=%0d: got %h want %h", s, out_comb, in8[s]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int r = 0; r < 60; r++) begin
            int s;
            @(negedge clk);
            s = int'($urandom_range(7, 0));
            for (int k = 0; k < 8; k++) in8[k] = 8'($urandom);
            sel = 3'(s);
            rst = ($urandom_range(7, 0) == 0);
            exp = rst ? 8'h00 : in8[s];
            @(posedge clk); #1;
            n_tests++;
            if (out_reg8 !== exp) begin
                n_fail++;
                $display("FAIL reg_back_to_back cycle %0d sel=%0d rst=%0b: got %h want %h",
                         r, s, rst, out_reg8, exp);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sel = 3'd0;
        for (int k = 0; k < 8; k++) begin
            in8[k]  = 8'h00;
            in16[k] = 16'h0000;
        end
        test_reset();
        test_comb_vector();
        test_isolation();
        test_registered_latency();
        test_reset_between_edges();
        test_width16();
        test_random_comb();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mux_8to1
